alu_connector: RTL and testbench

Registered RV32I arithmetic-logic unit for the RISC-V core datapath. It takes two 32-bit operands and a 4-bit operation code, and computes the result combinationally. The result and a zero flag are registered on the next rising clock edge. The block sits between the register-file/immediate operand muxes and the write-back/branch logic, and is the unit the core's ALU test exercises through the shared system interface signals (A_alu, B_alu, result_alu, zero_alu).

---
 rtl/alu_connector.sv | 80 ++++++++
 tb/tb_alu_connector.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_connector.sv
// alu_connector: registered RV32I ALU. The operation result is computed
// combinationally from the operands and op code, then captured together with
// its zero flag on the rising clock edge (one-cycle latency, fully pipelined).
module alu_connector #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] A_alu,
    input  logic [WIDTH-1:0] B_alu,
    input  logic [3:0]       ALU_control,
    output logic [WIDTH-1:0] result_alu,
    output logic             zero_alu
);

    localparam int SHW = $clog2(WIDTH);

    // Op codes are {funct7[5], funct3}.
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b1000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_SLT   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SRA   = 4'b1101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_PASSB = 4'b1111;

    logic [SHW-1:0]   shamt_s;
    logic             slt_s;
    logic             sltu_s;
    logic [WIDTH-1:0] result_s;
    logic             zero_s;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;

    // Only the low log2(WIDTH) bits of B select the shift distance.
    assign shamt_s = B_alu[SHW-1:0];
    assign slt_s   = ($signed(A_alu) < $signed(B_alu));
    assign sltu_s  = (A_alu < B_alu);

    // Next-state result: operation select; unused codes yield zero.
    always_comb begin
        result_s = {WIDTH{1'b0}};
        case (ALU_control)
            OP_ADD:   result_s = A_alu + B_alu;
            OP_SUB:   result_s = A_alu - B_alu;
            OP_SLL:   result_s = A_alu << shamt_s;
            OP_SLT:   result_s = {{(WIDTH-1){1'b0}}, slt_s};
            OP_SLTU:  result_s = {{(WIDTH-1){1'b0}}, sltu_s};
            OP_XOR:   result_s = A_alu ^ B_alu;
            OP_SRL:   result_s = A_alu >> shamt_s;
            OP_SRA:   result_s = $unsigned($signed(A_alu) >>> shamt_s);
            OP_OR:    result_s = A_alu | B_alu;
            OP_AND:   result_s = A_alu & B_alu;
            OP_PASSB: result_s = B_alu;
            default:  result_s = {WIDTH{1'b0}};
        endcase
    end

    // Zero flag comes from the same next-state value so both outputs agree.
    assign zero_s = (result_s == {WIDTH{1'b0}});

    // Output register; reset clears the result and raises the zero flag at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
        end else begin
            result_r <= result_s;
            zero_r   <= zero_s;
        end
    end

    assign result_alu = result_r;
    assign zero_alu   = zero_r;

endmodule

// File: tb/tb_alu_connector.sv
// tb_alu_connector: directed table of ALU vectors with hand-computed results,
// hand-written reset and latency sequences, then a random streaming run
// compared against an independent reference model.
module tb_alu_connector;

    logic        CLK;
    logic        RESET;
    logic [31:0] A_alu;
    logic [31:0] B_alu;
    logic [3:0]  ALU_control;
    logic [31:0] result_alu;
    logic        zero_alu;

    int n_vec;
    int n_fail;

    typedef struct {
        logic [63:0] name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic        exp_z;
    } vec_t;

    vec_t vecs[$];

    alu_connector #(.WIDTH(32)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .A_alu       (A_alu),
        .B_alu       (B_alu),
        .ALU_control (ALU_control),
        .result_alu  (result_alu),
        .zero_alu    (zero_alu)
    );

    // 10 ns clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic add_vec(input logic [63:0] name, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic z);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.exp_r = r; v.exp_z = z;
        vecs.push_back(v);
    endtask

    task automatic check(input logic [63:0] name, input logic [31:0] exp_r,
                         input logic exp_z);
        n_vec++;
        if (result_alu !== exp_r || zero_alu !== exp_z) begin
            n_fail++;
            $display("FAIL %s: result_alu=%h zero_alu=%b, expected %h / %b",
                     name, result_alu, zero_alu, exp_r, exp_z);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        ALU_control = op; A_alu = a; B_alu = b;
    endtask

    // Independent reference model written without the DUT's operator forms.
    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0]  sh;
        logic [31:0] fill;
        sh = b[4:0];
        fill = 32'hFFFF_FFFF;
        case (op)
            4'b0000: return a + b;
            4'b1000: return a + (~b) + 32'd1;
            4'b0001: return a << sh;
            4'b0010: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> sh;
            4'b1101: return (a >> sh) | (a[31] ? ~(fill >> sh) : 32'd0);
            4'b0110: return a | b;
            4'b0111: return a & b;
            4'b1111: return b;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        logic [31:0] exp_r;
        n_vec = 0;
        n_fail = 0;

        add_vec("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        add_vec("sub_zero", 4'b1000, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1);
        add_vec("sub_neg",  4'b1000, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0);
        add_vec("slt_neg",  4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
        add_vec("sltu",     4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        add_vec("slt_eq",   4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
        add_vec("sll_31",   4'b0001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0);
        add_vec("srl_4",    4'b0101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0);
        add_vec("sra_4",    4'b1101, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0);
        add_vec("sll_mask", 4'b0001, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0);
        add_vec("and",      4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
        add_vec("or",       4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0);
        add_vec("xor",      4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0);
        add_vec("passb",    4'b1111, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1'b0);
        add_vec("ill_1010", 4'b1010, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1);
        add_vec("ill_1001", 4'b1001, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1);
        add_vec("ill_1011", 4'b1011, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1);
        add_vec("ill_1100", 4'b1100, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1);
        add_vec("ill_1110", 4'b1110, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1);
        add_vec("add_5_3",  4'b0000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0);
        add_vec("sra_pos",  4'b1101, 32'h7000_0000, 32'h0000_0024, 32'h0700_0000, 1'b0);

        // Power-on reset state.
        RESET = 1'b1;
        drive(4'b0000, 32'h0000_0005, 32'h0000_0003);
        #1;
        check("rst_init", 32'h0000_0000, 1'b1);
        @(posedge CLK); #1;
        check("rst_hold", 32'h0000_0000, 1'b1);
        RESET = 1'b0;

        // Directed table, one vector per cycle (back-to-back).
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            @(posedge CLK); #1;
            check(vecs[i].name, vecs[i].exp_r, vecs[i].exp_z);
        end

        // Latency: new inputs must not show before the next edge.
        drive(4'b1000, 32'h0000_0007, 32'h0000_0007);
        #3;
        check("lat_old", 32'h0700_0000, 1'b0);
        @(posedge CLK); #1;
        check("lat_new", 32'h0000_0000, 1'b1);

        // Asynchronous reset between edges discards a nonzero result.
        drive(4'b0000, 32'h0000_0005, 32'h0000_0003);
        @(posedge CLK); #1;
        check("pre_rst", 32'h0000_0008, 1'b0);
        #2;
        RESET = 1'b1;
        #1;
        check("rst_async", 32'h0000_0000, 1'b1);
        drive(4'b0110, 32'h1111_1111, 32'h2222_2222);
        @(posedge CLK); #1;
        check("rst_held", 32'h0000_0000, 1'b1);
        drive(4'b0000, 32'h0000_0005, 32'h0000_0003);
        #3;
        RESET = 1'b0;
        #1;
        check("rst_rel", 32'h0000_0000, 1'b1);
        @(posedge CLK); #1;
        check("post_rst", 32'h0000_0008, 1'b0);

        // Random streaming against the reference model.
        for (int i = 0; i < 10000; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (i % 8 == 0) b = a;
            drive(op, a, b);
            exp_r = ref_alu(op, a, b);
            @(posedge CLK); #1;
            check("random", exp_r, (exp_r == 32'd0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
